// File: rtl/io_map_pkg.sv
// Shared CPU-bus address map for the nibble-mapped input/output registers.
// Holds the default address constants and the nibble address helper.
package io_map_pkg;

    localparam logic [15:0] INREG_BASE_ADDR = 16'd10;
    localparam logic [15:0] INREG_STRIDE    = 16'd4;
    localparam logic [15:0] INREG_STAT_ADDR = 16'd6;
    localparam logic [15:0] INREG_ACK_ADDR  = 16'd7;
    localparam int          NIBBLES         = 16;

    function automatic logic [15:0] nibble_addr(input logic [15:0] base,
                                                input logic [15:0] stride,
                                                input logic [3:0]  idx);
        return base + stride * {12'b0, idx};
    endfunction

endpackage

// File: rtl/inreg_fifo2.sv
// Two-entry 64-bit FIFO with head output; storage itself is never reset.
module inreg_fifo2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [63:0] din,
    output logic [63:0] head,
    output logic [1:0]  count
);

    logic [63:0] slot [2];
    logic        wr_ptr;
    logic        rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            slot[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = slot[rd_ptr];

endmodule

// File: rtl/inreg.sv
// Memory-mapped input register: buffers source words in a 2-deep FIFO and
// exposes the head word nibble by nibble, plus status and pop (ACK) reads.
module inreg
    import io_map_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = INREG_BASE_ADDR,
    parameter logic [15:0] STRIDE    = INREG_STRIDE,
    parameter logic [15:0] STAT_ADDR = INREG_STAT_ADDR,
    parameter logic [15:0] ACK_ADDR  = INREG_ACK_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        rd,
    input  logic [15:0] addr,
    output logic [3:0]  q,
    output logic        hit
);

    logic [63:0] head;
    logic [1:0]  count;
    logic        empty;
    logic        push;
    logic        pop;
    logic        pop_err;
    logic        is_stat;
    logic        is_ack;
    logic        nib_hit;
    logic [3:0]  nib_sel;
    logic [3:0]  nib_val;
    logic [3:0]  head_nib0;
    logic [3:0]  rdata;
    logic        decoded;
    logic        err;

    assign empty    = (count == 2'd0);
    assign in_ready = (count != 2'd2);
    assign push     = in_valid && in_ready;
    assign is_stat  = (addr == STAT_ADDR);
    assign is_ack   = (addr == ACK_ADDR);
    assign pop      = rd && is_ack && !empty;
    assign pop_err  = rd && is_ack && empty;

    always_comb begin
        nib_hit = 1'b0;
        nib_sel = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (addr == nibble_addr(BASE_ADDR, STRIDE, 4'(i))) begin
                nib_hit = 1'b1;
                nib_sel = 4'(i);
            end
        end
    end

    // An empty FIFO reads as zero; the slot contents are stale then.
    assign nib_val   = empty ? 4'h0 : head[{nib_sel, 2'b00} +: 4];
    assign head_nib0 = empty ? 4'h0 : head[3:0];
    assign decoded   = is_stat || is_ack || nib_hit;

    always_comb begin
        rdata = nib_val;
        if (is_stat) begin
            rdata = {err, 1'b0, count};
        end else if (is_ack) begin
            rdata = head_nib0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= 4'h0;
            hit <= 1'b0;
            err <= 1'b0;
        end else begin
            hit <= rd && decoded;
            if (rd && decoded) begin
                q <= rdata;
            end
            // A new underflow outranks the clear-on-read of status.
            if (pop_err) begin
                err <= 1'b1;
            end else if (rd && is_stat) begin
                err <= 1'b0;
            end
        end
    end

    inreg_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_inreg.sv
// Self-checking bench for inreg: directed scenarios plus a randomized run
// against a queue-based model of the register map.
module tb_inreg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'h0;
    logic        rd = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [3:0]  q;
    logic        hit;

    int total = 0;
    int passed = 0;

    logic [63:0] mq [$];
    logic        m_err = 1'b0;
    logic [3:0]  exp_q = 4'h0;
    logic        exp_hit = 1'b0;

    always #5 clk = ~clk;

    inreg dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .rd       (rd),
        .addr     (addr),
        .q        (q),
        .hit      (hit)
    );

    // Applies one cycle of stimulus, advances the model across the edge and
    // leaves the bench 1 time unit after that edge.
    task automatic step(input logic v, input logic [63:0] d, input logic r,
                        input logic [15:0] a, input logic rs);
        int  sz;
        bit  is_nib;
        int  idx;
        bit  ready;
        rst = rs; in_valid = v; in_data = d; rd = r; addr = a;
        sz     = mq.size();
        ready  = (sz != 2);
        is_nib = (a >= 16'd10) && (a <= 16'd70) && (((a - 16'd10) % 4) == 0);
        idx    = (int'(a) - 10) / 4;
        if (rs) begin
            mq.delete();
            m_err   = 1'b0;
            exp_q   = 4'h0;
            exp_hit = 1'b0;
        end else begin
            exp_hit = r && (a == 16'd6 || a == 16'd7 || is_nib);
            if (r && a == 16'd6) begin
                exp_q = {m_err, 1'b0, 2'(sz)};
            end else if (r && a == 16'd7) begin
                exp_q = (sz == 0) ? 4'h0 : mq[0][3:0];
            end else if (r && is_nib) begin
                exp_q = (sz == 0) ? 4'h0 : 4'((mq[0] >> (4 * idx)) & 64'hF);
            end
            if (r && a == 16'd7 && sz == 0) m_err = 1'b1;
            else if (r && a == 16'd6) m_err = 1'b0;
            if (r && a == 16'd7 && sz != 0) void'(mq.pop_front());
            if (v && ready) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 64'h0, 1'b0, 16'h0, 1'b1);
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else passed++;
        total++;
        if (q !== 4'h0 || hit !== 1'b0) $display("FAIL reset_q_hit: got q=%h hit=%b want q=0 hit=0", q, hit);
        else passed++;
        step(1'b0, 64'h0, 1'b1, 16'd6, 1'b0);
        total++;
        if (q !== 4'h0 || hit !== 1'b1) $display("FAIL reset_stat: got q=%h hit=%b want q=0 hit=1", q, hit);
        else passed++;
    endtask

    task automatic test_nibbles();
        step(1'b1, 64'hFEDCBA9876543210, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 64'h0, 1'b1, 16'(10 + 4 * i), 1'b0);
            total++;
            if (q !== 4'(i) || hit !== 1'b1)
                $display("FAIL nibble_%0d: got q=%h hit=%b want q=%h hit=1", i, q, hit, 4'(i));
            else passed++;
        end
        step(1'b0, 64'h0, 1'b1, 16'd7, 1'b0);
        total++;
        if (q !== 4'h0 || hit !== 1'b1) $display("FAIL nibble_ack: got q=%h hit=%b want q=0 hit=1", q, hit);
        else passed++;
    endtask

    task automatic test_full_backpressure();
        logic [63:0] wa = 64'h1111_2222_3333_444A;
        logic [63:0] wb = 64'h5555_6666_7777_888B;
        logic [63:0] wc = 64'h9999_AAAA_BBBB_CCCC;
        step(1'b0, 64'h0, 1'b0, 16'h0, 1'b1);
        step(1'b1, wa, 1'b0, 16'h0, 1'b0);
        step(1'b1, wb, 1'b0, 16'h0, 1'b0);
        total++;
        if (in_ready !== 1'b0) $display("FAIL full_ready_low: got %b want 0", in_ready);
        else passed++;
        step(1'b1, wc, 1'b0, 16'h0, 1'b0);
        total++;
        if (in_ready !== 1'b0) $display("FAIL full_c_waits: got %b want 0", in_ready);
        else passed++;
        step(1'b1, wc, 1'b1, 16'd7, 1'b0);
        total++;
        if (q !== 4'hA || in_ready !== 1'b1)
            $display("FAIL full_ack: got q=%h ready=%b want q=a ready=1", q, in_ready);
        else passed++;
        step(1'b1, wc, 1'b0, 16'h0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 16'd6, 1'b0);
        total++;
        if (q !== 4'h2) $display("FAIL full_stat: got q=%h want 2", q);
        else passed++;
        step(1'b0, 64'h0, 1'b1, 16'd10, 1'b0);
        total++;
        if (q !== 4'hB) $display("FAIL full_head_b: got q=%h want b", q);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] w1 = 64'h0123_4567_89AB_CDE5;
        logic [63:0] w2 = 64'hDEAD_BEEF_0BAD_F00D;
        step(1'b0, 64'h0, 1'b0, 16'h0, 1'b1);
        step(1'b1, w1, 1'b1, 16'd10, 1'b0);
        total++;
        if (q !== 4'h0 || hit !== 1'b1) $display("FAIL push_empty_read: got q=%h hit=%b want q=0 hit=1", q, hit);
        else passed++;
        step(1'b1, w2, 1'b1, 16'd7, 1'b0);
        total++;
        if (q !== 4'h5) $display("FAIL b2b_ack: got q=%h want 5", q);
        else passed++;
        step(1'b0, 64'h0, 1'b1, 16'd6, 1'b0);
        total++;
        if (q !== 4'h1) $display("FAIL b2b_count: got q=%h want 1", q);
        else passed++;
        step(1'b0, 64'h0, 1'b1, 16'd70, 1'b0);
        total++;
        if (q !== 4'hD) $display("FAIL b2b_head_n15: got q=%h want d", q);
        else passed++;
    endtask

    task automatic test_underflow();
        step(1'b0, 64'h0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 64'h0, 1'b1, 16'd7, 1'b0);
        total++;
        if (q !== 4'h0 || hit !== 1'b1) $display("FAIL uf_ack: got q=%h hit=%b want q=0 hit=1", q, hit);
        else passed++;
        step(1'b0, 64'h0, 1'b1, 16'd6, 1'b0);
        total++;
        if (q !== 4'h8) $display("FAIL uf_stat1: got q=%h want 8", q);
        else passed++;
        step(1'b0, 64'h0, 1'b1, 16'd6, 1'b0);
        total++;
        if (q !== 4'h0) $display("FAIL uf_stat2: got q=%h want 0", q);
        else passed++;
    endtask

    task automatic test_reset_midway();
        step(1'b1, 64'h7777_7777_7777_7777, 1'b0, 16'h0, 1'b0);
        step(1'b1, 64'h3333_3333_3333_3333, 1'b0, 16'h0, 1'b0);
        step(1'b1, 64'h5555_5555_5555_5555, 1'b1, 16'd10, 1'b1);
        total++;
        if (in_ready !== 1'b1 || hit !== 1'b0)
            $display("FAIL rst_mid: got ready=%b hit=%b want ready=1 hit=0", in_ready, hit);
        else passed++;
        step(1'b0, 64'h0, 1'b1, 16'd10, 1'b0);
        total++;
        if (q !== 4'h0 || hit !== 1'b1) $display("FAIL rst_mid_read: got q=%h hit=%b want q=0 hit=1", q, hit);
        else passed++;
        step(1'b0, 64'h0, 1'b1, 16'd8, 1'b0);
        total++;
        if (hit !== 1'b0 || q !== 4'h0) $display("FAIL rst_mid_addr8: got q=%h hit=%b want q=0 hit=0", q, hit);
        else passed++;
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [63:0] d;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0:       a = 16'd6;
                1:       a = 16'd7;
                4:       a = 16'($urandom_range(0, 80));
                default: a = 16'(10 + 4 * $urandom_range(0, 15));
            endcase
            d = {$urandom, $urandom};
            step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 9) < 6), a,
                 1'($urandom_range(0, 49) == 0));
            total++;
            if (q !== exp_q || hit !== exp_hit || in_ready !== (mq.size() != 2))
                $display("FAIL rand_%0d: got q=%h hit=%b ready=%b want q=%h hit=%b ready=%b",
                         n, q, hit, in_ready, exp_q, exp_hit, (mq.size() != 2));
            else passed++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_nibbles();
        test_full_backpressure();
        test_back_to_back();
        test_underflow();
        test_reset_midway();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
